// File: rtl/leaf_stream_fifo.sv
// -----------------------------------------------------------------------------
// leaf_stream_fifo
//   Elastic buffer between a user operator output stream (ap_vld/ap_ack) and a
//   leaf_interface user input port (din_leaf_user2interface / vld / ack).
//   It absorbs network back-pressure so the operator pipeline keeps running
//   while packets wait for the BFT. The handshake is the same on both sides,
//   and delivery is in order and lossless.
//
// Ports
//   clk_user     in   1               clock (single domain)
//   reset        in   1               synchronous, active-high reset
//   din          in   PAYLOAD_BITS    word from operator
//   din_vld      in   1               operator word valid
//   din_ack      out  1               buffer accepts word (from state + reset only)
//   dout         out  PAYLOAD_BITS    head word (first-word fall-through)
//   dout_vld     out  1               head word valid
//   dout_ack     in   1               consumer accepts head word
//   count        out  DEPTH_BITS+1    current occupancy, 0..DEPTH
//   almost_full  out  1               count >= ALMOST_FULL_THRESH
//   high_water   out  DEPTH_BITS+1    max occupancy since reset   (stats build)
//   xfer_count   out  32              pops since reset, wrapping  (stats build)
//
// Build option
//   LEAF_STREAM_FIFO_STATS_EN : adds the high_water / xfer_count statistics.
// -----------------------------------------------------------------------------
module leaf_stream_fifo #(
  parameter int unsigned PAYLOAD_BITS       = 32,
  parameter int unsigned DEPTH_BITS         = 4,
  parameter int unsigned ALMOST_FULL_THRESH = 12
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    din_vld,
  output logic                    din_ack,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    dout_vld,
  input  logic                    dout_ack,
  output logic [DEPTH_BITS:0]     count,
`ifdef LEAF_STREAM_FIFO_STATS_EN
  output logic [DEPTH_BITS:0]     high_water,
  output logic [31:0]             xfer_count,
`endif
  output logic                    almost_full
);

  localparam int unsigned DEPTH = 2 ** DEPTH_BITS;
  localparam int unsigned CNT_W = DEPTH_BITS + 1;

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [DEPTH_BITS-1:0]   wr_ptr;
  logic [DEPTH_BITS-1:0]   rd_ptr;
  logic                    push;
  logic                    pop;

  // Handshake outputs derive from registered occupancy and reset only, so
  // there is no combinational path from din_vld back to din_ack.
  always_comb begin
    din_ack     = ~reset & (count != CNT_W'(DEPTH));
    dout_vld    = ~reset & (count != '0);
    almost_full = ~reset & (count >= CNT_W'(ALMOST_FULL_THRESH));
    dout        = mem[rd_ptr];
    push        = din_vld & din_ack;
    pop         = dout_vld & dout_ack;
  end

  // Storage: written on push, never reset so it can map to distributed RAM.
  always_ff @(posedge clk_user) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef LEAF_STREAM_FIFO_STATS_EN
  // High-water tracks the registered occupancy, so it lags count by one edge.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      high_water <= '0;
      xfer_count <= '0;
    end else begin
      if (count > high_water) begin
        high_water <= count;
      end
      if (pop) begin
        xfer_count <= xfer_count + 32'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_leaf_stream_fifo
//   Directed self-checking bench for leaf_stream_fifo. Inputs change and
//   outputs are sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_leaf_stream_fifo;

  logic        clk_user = 1'b0;
  logic        reset    = 1'b1;
  logic [31:0] din      = '0;
  logic        din_vld  = 1'b0;
  logic        din_ack;
  logic [31:0] dout;
  logic        dout_vld;
  logic        dout_ack = 1'b0;
  logic [4:0]  count;
  logic        almost_full;
`ifdef LEAF_STREAM_FIFO_STATS_EN
  logic [4:0]  high_water;
  logic [31:0] xfer_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_user = ~clk_user;

  leaf_stream_fifo #(
    .PAYLOAD_BITS       (32),
    .DEPTH_BITS         (4),
    .ALMOST_FULL_THRESH (12)
  ) dut (
    .clk_user    (clk_user),
    .reset       (reset),
    .din         (din),
    .din_vld     (din_vld),
    .din_ack     (din_ack),
    .dout        (dout),
    .dout_vld    (dout_vld),
    .dout_ack    (dout_ack),
    .count       (count),
`ifdef LEAF_STREAM_FIFO_STATS_EN
    .high_water  (high_water),
    .xfer_count  (xfer_count),
`endif
    .almost_full (almost_full)
  );

  task automatic tick();
    @(posedge clk_user);
    #1;
  endtask

  task automatic pulse_reset();
    din_vld  = 1'b0;
    dout_ack = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    #1;
  endtask

  // Push n words base..base+n-1 with the output side stalled.
  task automatic fill(input logic [31:0] base, input int n);
    dout_ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      din     = base + 32'(i);
      din_vld = 1'b1;
      tick();
    end
    din_vld = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    din_vld = 1'b1;
    din     = 32'h1111_1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (din_ack !== 1'b0 || dout_vld !== 1'b0 || count !== 5'd0 || almost_full !== 1'b0) begin
        miscompares++;
        $display("FAIL reset cyc%0d: din_ack=%b dout_vld=%b count=%0d af=%b, want 0 0 0 0",
                 c, din_ack, dout_vld, count, almost_full);
      end
    end
    reset   = 1'b0;
    din_vld = 1'b0;
    #1;
    vectors++;
    if (din_ack !== 1'b1 || dout_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: din_ack=%b dout_vld=%b, want 1 0", din_ack, dout_vld);
    end
  endtask

  task automatic test_single();
    dout_ack = 1'b0;
    din      = 32'hDEAD_BEEF;
    din_vld  = 1'b1;
    tick();
    din_vld  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (dout_vld !== 1'b1 || dout !== 32'hDEAD_BEEF || count !== 5'd1) begin
        miscompares++;
        $display("FAIL single_hold cyc%0d: vld=%b dout=%h count=%0d, want 1 deadbeef 1",
                 c, dout_vld, dout, count);
      end
      tick();
    end
    dout_ack = 1'b1;
    tick();
    vectors++;
    if (dout_vld !== 1'b0 || count !== 5'd0) begin
      miscompares++;
      $display("FAIL single_pop: vld=%b count=%0d, want 0 0", dout_vld, count);
    end
    // dout_ack while empty must not underflow
    tick();
    dout_ack = 1'b0;
    vectors++;
    if (dout_vld !== 1'b0 || count !== 5'd0) begin
      miscompares++;
      $display("FAIL empty_ack: vld=%b count=%0d, want 0 0", dout_vld, count);
    end
  endtask

  task automatic test_fill_drain();
    pulse_reset();
    dout_ack = 1'b0;
    for (int i = 0; i < 17; i++) begin
      din     = 32'(i);
      din_vld = 1'b1;
      #1;
      vectors++;
      if (din_ack !== (i < 16) || almost_full !== (i >= 12) || count !== 5'((i < 16) ? i : 16)) begin
        miscompares++;
        $display("FAIL fill i=%0d: din_ack=%b af=%b count=%0d, want %b %b %0d",
                 i, din_ack, almost_full, count, (i < 16), (i >= 12), (i < 16) ? i : 16);
      end
      tick();
    end
    din_vld = 1'b0;
    #1;
    vectors++;
    if (count !== 5'd16 || din_ack !== 1'b0 || almost_full !== 1'b1) begin
      miscompares++;
      $display("FAIL full: count=%0d din_ack=%b af=%b, want 16 0 1", count, din_ack, almost_full);
    end
    dout_ack = 1'b1;
    for (int j = 0; j < 16; j++) begin
      vectors++;
      if (dout_vld !== 1'b1 || dout !== 32'(j)) begin
        miscompares++;
        $display("FAIL drain j=%0d: vld=%b dout=%0d, want 1 %0d", j, dout_vld, dout, j);
      end
      tick();
    end
    dout_ack = 1'b0;
    #1;
    vectors++;
    if (count !== 5'd0 || dout_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL drained: count=%0d vld=%b, want 0 0", count, dout_vld);
    end
`ifdef LEAF_STREAM_FIFO_STATS_EN
    tick();
    vectors++;
    if (high_water !== 5'd16 || xfer_count !== 32'd16) begin
      miscompares++;
      $display("FAIL stats: high_water=%0d xfer_count=%0d, want 16 16", high_water, xfer_count);
    end
`endif
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    fill(32'd100, 5);
    vectors++;
    if (count !== 5'd5) begin
      miscompares++;
      $display("FAIL b2b_prefill: count=%0d, want 5", count);
    end
    din_vld  = 1'b1;
    dout_ack = 1'b1;
    for (int k = 0; k < 40; k++) begin
      din = 32'd105 + 32'(k);
      #1;
      vectors++;
      if (count !== 5'd5 || dout !== 32'd100 + 32'(k) || din_ack !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b k=%0d: count=%0d dout=%0d ack=%b, want 5 %0d 1",
                 k, count, dout, din_ack, 100 + k);
      end
      tick();
    end
    din_vld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (dout_vld !== 1'b1 || dout !== 32'd140 + 32'(k)) begin
        miscompares++;
        $display("FAIL b2b_tail k=%0d: vld=%b dout=%0d, want 1 %0d", k, dout_vld, dout, 140 + k);
      end
      tick();
    end
    dout_ack = 1'b0;
    #1;
    vectors++;
    if (count !== 5'd0) begin
      miscompares++;
      $display("FAIL b2b_end: count=%0d, want 0", count);
    end
  endtask

  task automatic test_full_pop();
    pulse_reset();
    fill(32'd200, 16);
    din      = 32'd300;
    din_vld  = 1'b1;
    dout_ack = 1'b1;
    #1;
    vectors++;
    if (din_ack !== 1'b0 || dout !== 32'd200 || count !== 5'd16) begin
      miscompares++;
      $display("FAIL fullpop_a: din_ack=%b dout=%0d count=%0d, want 0 200 16", din_ack, dout, count);
    end
    tick();
    dout_ack = 1'b0;
    #1;
    vectors++;
    if (count !== 5'd15 || din_ack !== 1'b1 || dout !== 32'd201) begin
      miscompares++;
      $display("FAIL fullpop_b: count=%0d din_ack=%b dout=%0d, want 15 1 201", count, din_ack, dout);
    end
    tick();
    din_vld = 1'b0;
    #1;
    vectors++;
    if (count !== 5'd16) begin
      miscompares++;
      $display("FAIL fullpop_c: count=%0d, want 16", count);
    end
    dout_ack = 1'b1;
    for (int j = 0; j < 16; j++) begin
      vectors++;
      if (dout_vld !== 1'b1 || dout !== ((j < 15) ? 32'd201 + 32'(j) : 32'd300)) begin
        miscompares++;
        $display("FAIL fullpop_drain j=%0d: vld=%b dout=%0d, want 1 %0d",
                 j, dout_vld, dout, (j < 15) ? 201 + j : 300);
      end
      tick();
    end
    dout_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    fill(32'h50, 7);
    vectors++;
    if (count !== 5'd7) begin
      miscompares++;
      $display("FAIL rstmid_fill: count=%0d, want 7", count);
    end
    reset    = 1'b1;
    din      = 32'h77;
    din_vld  = 1'b1;
    dout_ack = 1'b1;
    #1;
    vectors++;
    if (din_ack !== 1'b0 || dout_vld !== 1'b0 || almost_full !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_in: din_ack=%b vld=%b af=%b, want 0 0 0", din_ack, dout_vld, almost_full);
    end
    tick();
    reset    = 1'b0;
    din_vld  = 1'b0;
    dout_ack = 1'b0;
    #1;
    vectors++;
    if (count !== 5'd0 || dout_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_after: count=%0d vld=%b, want 0 0", count, dout_vld);
    end
`ifdef LEAF_STREAM_FIFO_STATS_EN
    vectors++;
    if (high_water !== 5'd0 || xfer_count !== 32'd0) begin
      miscompares++;
      $display("FAIL rstmid_stats: high_water=%0d xfer_count=%0d, want 0 0", high_water, xfer_count);
    end
`endif
    din     = 32'hA5;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    #1;
    vectors++;
    if (dout_vld !== 1'b1 || dout !== 32'hA5 || count !== 5'd1) begin
      miscompares++;
      $display("FAIL rstmid_first: vld=%b dout=%h count=%0d, want 1 a5 1", dout_vld, dout, count);
    end
    dout_ack = 1'b1;
    tick();
    dout_ack = 1'b0;
    #1;
    vectors++;
    if (dout_vld !== 1'b0 || count !== 5'd0) begin
      miscompares++;
      $display("FAIL rstmid_empty: vld=%b count=%0d, want 0 0", dout_vld, count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_full_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
